// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared AXI4-Lite response codes, default widths and byte-merge helper
package axil_pkg;

  localparam int AXIL_ADDR_WIDTH = 32;
  localparam int AXIL_DATA_WIDTH = 32;
  localparam int AXIL_NUM_REGS   = 16;

  typedef logic [1:0] axil_resp_t;

  localparam axil_resp_t RESP_OKAY   = 2'b00;
  localparam axil_resp_t RESP_SLVERR = 2'b10;

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] result;
    result = old_word;
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) result[8*k +: 8] = new_word[8*k +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/modport_slave.sv
// rtl/modport_slave.sv - AXI4-Lite register-file slave with flat register output
module modport_slave
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = AXIL_ADDR_WIDTH,
  parameter int DATA_WIDTH = AXIL_DATA_WIDTH,
  parameter int NUM_REGS   = AXIL_NUM_REGS
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic [2:0]                     ARPROT,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic [2:0]                     AWPROT,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int SEL_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int STRB_W = DATA_WIDTH / 8;

  function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
    return idx < IDX_W'(NUM_REGS);
  endfunction

  function automatic logic [SEL_W-1:0] sel_of(input logic [IDX_W-1:0] idx);
    return idx[SEL_W-1:0];
  endfunction

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Low during reset and for the reset cycle itself; keeps all READYs closed.
  logic live;

  logic                  aw_held, w_held;
  logic [IDX_W-1:0]      aw_idx_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;

  logic                  aw_fire, w_fire, commit, wr_ok;
  logic [IDX_W-1:0]      wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;

  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic                  ar_fire;
  logic [IDX_W-1:0]      rd_idx;

  logic unused_inputs;
  assign unused_inputs = ^{ARPROT, AWPROT, ARADDR[1:0], AWADDR[1:0]};

  always_ff @(posedge ACLK) begin
    live <= !ARESET;
  end

  // Write channel: AW and W latch independently, commit once both are present.
  assign AWREADY = live && !aw_held && !bvalid_q;
  assign WREADY  = live && !w_held && !bvalid_q;
  assign aw_fire = AWVALID && AWREADY;
  assign w_fire  = WVALID && WREADY;

  assign wr_idx  = aw_held ? aw_idx_q : AWADDR[ADDR_WIDTH-1:2];
  assign wr_data = w_held ? w_data_q : WDATA;
  assign wr_strb = w_held ? w_strb_q : WSTRB;
  assign commit  = (aw_held || aw_fire) && (w_held || w_fire);
  assign wr_ok   = idx_ok(wr_idx);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else if (commit) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      bvalid_q <= 1'b1;
      bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (aw_fire) begin
        aw_held  <= 1'b1;
        aw_idx_q <= AWADDR[ADDR_WIDTH-1:2];
      end
      if (w_fire) begin
        w_held   <= 1'b1;
        w_data_q <= WDATA;
        w_strb_q <= WSTRB;
      end
      if (bvalid_q && BREADY) bvalid_q <= 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit && wr_ok) begin
      regs[sel_of(wr_idx)] <= merge_bytes(regs[sel_of(wr_idx)], wr_data, wr_strb);
    end
  end

  assign BVALID = bvalid_q;
  assign BRESP  = bresp_q;

  // Read channel: single outstanding read, data registered on the AR handshake.
  assign ARREADY = live && !rvalid_q;
  assign ar_fire = ARVALID && ARREADY;
  assign rd_idx  = ARADDR[ADDR_WIDTH-1:2];

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_fire) begin
      rvalid_q <= 1'b1;
      if (idx_ok(rd_idx)) begin
        rdata_q <= regs[sel_of(rd_idx)];
        rresp_q <= RESP_OKAY;
      end else begin
        rdata_q <= '0;
        rresp_q <= RESP_SLVERR;
      end
    end else if (rvalid_q && RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  assign RVALID = rvalid_q;
  assign RDATA  = rdata_q;
  assign RRESP  = rresp_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

endmodule

// File: tb/tb_modport_slave.sv
// tb/tb_modport_slave.sv - directed and randomized bench for modport_slave against a register-array model
module tb_modport_slave;
  import axil_pkg::*;

  logic         ACLK = 1'b0;
  logic         ARESET;
  logic [31:0]  ARADDR;
  logic [2:0]   ARPROT;
  logic         ARVALID;
  logic         ARREADY;
  logic [31:0]  RDATA;
  logic [1:0]   RRESP;
  logic         RVALID;
  logic         RREADY;
  logic [31:0]  AWADDR;
  logic [2:0]   AWPROT;
  logic         AWVALID;
  logic         AWREADY;
  logic [31:0]  WDATA;
  logic [3:0]   WSTRB;
  logic         WVALID;
  logic         WREADY;
  logic [1:0]   BRESP;
  logic         BVALID;
  logic         BREADY;
  logic [511:0] regs_o;

  modport_slave dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .regs_o(regs_o)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;
  int b_hs = 0;
  int r_hs = 0;
  logic [31:0] model [16];

  always @(negedge ACLK) begin
    if (BVALID && BREADY) b_hs++;
    if (RVALID && RREADY) r_hs++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] model_vec();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = model[i];
    return v;
  endfunction

  task automatic chk_regs(input string tag);
    logic [511:0] exp;
    exp = model_vec();
    checks++;
    assert (regs_o === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, regs_o, exp);
    end
  endtask

  function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                             input logic [3:0] strb);
    logic [29:0] idx;
    idx = addr[31:2];
    if (idx >= 30'd16) return RESP_SLVERR;
    for (int k = 0; k < 4; k++)
      if (strb[k]) model[idx[3:0]][8*k +: 8] = data[8*k +: 8];
    return RESP_OKAY;
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int hold, input string tag);
    bit aw_done, w_done, aw_f, w_f;
    int n, b0;
    logic [1:0] exp_resp;
    aw_done = 0; w_done = 0; n = 0; b0 = b_hs;
    exp_resp = model_write(addr, data, strb);
    BREADY = (hold == 0);
    while (!(aw_done && w_done) && n < 50) begin
      AWADDR  = addr;
      AWPROT  = 3'($urandom);
      WDATA   = data;
      WSTRB   = strb;
      AWVALID = !aw_done && (n >= aw_dly);
      WVALID  = !w_done && (n >= w_dly);
      aw_f = AWVALID && AWREADY;
      w_f  = WVALID && WREADY;
      @(posedge ACLK); #1;
      aw_done |= aw_f;
      w_done  |= w_f;
      n++;
    end
    AWVALID = 0;
    WVALID  = 0;
    chk({tag, " bvalid"}, BVALID, 1);
    chk({tag, " bresp"}, BRESP, exp_resp);
    chk_regs({tag, " regs"});
    for (int i = 0; i < hold; i++) begin
      @(posedge ACLK); #1;
      chk({tag, " bvalid hold"}, BVALID, 1);
      chk({tag, " bresp hold"}, BRESP, exp_resp);
      chk({tag, " ready closed"}, {AWREADY, WREADY}, 2'b00);
    end
    BREADY = 1;
    @(posedge ACLK); #1;
    chk({tag, " bvalid cleared"}, BVALID, 0);
    chk({tag, " b pulses"}, b_hs - b0, 1);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int ar_dly, input int hold, input string tag);
    logic [29:0] idx;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    bit done, f;
    int n;
    idx = addr[31:2];
    exp_data = (idx < 30'd16) ? model[idx[3:0]] : 32'h0;
    exp_resp = (idx < 30'd16) ? RESP_OKAY : RESP_SLVERR;
    RREADY = (hold == 0);
    repeat (ar_dly) begin @(posedge ACLK); #1; end
    done = 0; n = 0;
    while (!done && n < 50) begin
      ARADDR  = addr;
      ARPROT  = 3'($urandom);
      ARVALID = 1;
      f = ARREADY;
      @(posedge ACLK); #1;
      done = f;
      n++;
    end
    ARVALID = 0;
    chk({tag, " rvalid"}, RVALID, 1);
    chk({tag, " rdata"}, RDATA, exp_data);
    chk({tag, " rresp"}, RRESP, exp_resp);
    for (int i = 0; i < hold; i++) begin
      @(posedge ACLK); #1;
      chk({tag, " rvalid hold"}, RVALID, 1);
      chk({tag, " rdata hold"}, RDATA, exp_data);
      chk({tag, " arready closed"}, ARREADY, 0);
    end
    RREADY = 1;
    @(posedge ACLK); #1;
    chk({tag, " rvalid cleared"}, RVALID, 0);
  endtask

  initial begin
    logic [31:0] old_word, rnd_addr, rnd_data;
    logic [1:0]  resp;
    int          b_before;

    ARESET = 1; ARADDR = 0; ARPROT = 0; ARVALID = 0; RREADY = 1;
    AWADDR = 0; AWPROT = 0; AWVALID = 0; WDATA = 0; WSTRB = 0; WVALID = 0; BREADY = 1;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;

    repeat (3) @(posedge ACLK);
    #1;
    chk("reset readies", {ARREADY, AWREADY, WREADY}, 3'b000);
    chk("reset valids", {RVALID, BVALID}, 2'b00);
    chk("reset rdata", RDATA, 0);
    chk("reset resps", {RRESP, BRESP}, 4'b0000);
    chk_regs("reset regs");
    ARESET = 0;
    @(posedge ACLK); #1;
    chk("post-reset readies", {ARREADY, AWREADY, WREADY}, 3'b111);

    axi_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, "w04");
    axi_read(32'h04, 0, 0, "r04");
    chk("r04 flat", regs_o[63:32], 32'hDEADBEEF);

    axi_write(32'h08, 32'h11223344, 4'h5, 0, 0, 0, "w08 strb5");
    axi_read(32'h08, 0, 0, "r08");
    chk("r08 flat", regs_o[95:64], 32'h00220044);

    axi_write(32'h0C, 32'hA5A55A5A, 4'hF, 3, 0, 0, "w0c w-first");
    b_before = b_hs;
    repeat (3) begin @(posedge ACLK); #1; end
    chk("w0c no extra b", b_hs - b_before, 0);
    axi_write(32'h18, 32'h01020304, 4'hF, 0, 2, 0, "w18 aw-first");

    axi_read(32'h40, 0, 0, "r40 oor");
    axi_write(32'h40, 32'hFFFFFFFF, 4'hF, 0, 0, 0, "w40 oor");

    axi_write(32'h10, 32'hCAFEF00D, 4'hF, 0, 0, 5, "w10 hold");
    axi_read(32'h10, 0, 5, "r10 hold");

    axi_write(32'h04, 32'h0, 4'h0, 0, 0, 0, "w04 strb0");

    old_word = model[3];
    rnd_data = $urandom;
    ARADDR = 32'h0C; AWADDR = 32'h0C; WDATA = rnd_data; WSTRB = 4'hF;
    ARVALID = 1; AWVALID = 1; WVALID = 1;
    @(posedge ACLK); #1;
    ARVALID = 0; AWVALID = 0; WVALID = 0;
    resp = model_write(32'h0C, rnd_data, 4'hF);
    chk("same-edge rvalid", RVALID, 1);
    chk("same-edge old data", RDATA, old_word);
    chk("same-edge bvalid", BVALID, 1);
    chk("same-edge bresp", BRESP, resp);
    chk_regs("same-edge regs");
    @(posedge ACLK); #1;
    chk("same-edge done", {RVALID, BVALID}, 2'b00);

    for (int t = 0; t < 40; t++) begin
      rnd_addr = 32'($urandom_range(0, 32'h4F));
      rnd_data = $urandom;
      if ($urandom_range(0, 1) == 1)
        axi_write(rnd_addr, rnd_data, 4'($urandom), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), "rand w");
      else
        axi_read(rnd_addr, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), "rand r");
    end

    b_before = b_hs;
    AWADDR = 32'h14; AWVALID = 1;
    @(posedge ACLK); #1;
    AWVALID = 0;
    chk("aw-only latched", AWREADY, 0);
    chk("aw-only no b", BVALID, 0);
    ARESET = 1;
    @(posedge ACLK); #1;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    chk("mid-reset readies", {ARREADY, AWREADY, WREADY}, 3'b000);
    chk_regs("mid-reset regs");
    ARESET = 0;
    @(posedge ACLK); #1;
    chk("after reset readies", {ARREADY, AWREADY, WREADY}, 3'b111);
    repeat (3) begin @(posedge ACLK); #1; end
    chk("abandoned no b", b_hs - b_before, 0);
    chk("abandoned bvalid", BVALID, 0);
    axi_write(32'h14, 32'h5EED1234, 4'hF, 1, 0, 0, "fresh w14");
    axi_read(32'h14, 0, 0, "fresh r14");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/modport_slave.md
MODPORT_SLAVE -- requirements
Module: modport_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: AXI4-Lite address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width, fixed to 32.
REQ-003 SHALL have parameter NUM_REGS, default 16: number of 32-bit registers.
REQ-004 SHALL have one clock and a synchronous active-high reset: ACLK  in  1  clock, rising edge; ARESET  in  1  reset.
REQ-005 SHALL have ports ARADDR in ADDR_WIDTH, ARPROT in 3, ARVALID in 1, ARREADY out 1: read address channel.
REQ-006 SHALL have ports RDATA out DATA_WIDTH, RRESP out 2, RVALID out 1, RREADY in 1: read data channel.
REQ-007 SHALL have ports AWADDR in ADDR_WIDTH, AWPROT in 3, AWVALID in 1, AWREADY out 1: write address channel.
REQ-008 SHALL have ports WDATA in DATA_WIDTH, WSTRB in DATA_WIDTH/8, WVALID in 1, WREADY out 1: write data channel.
REQ-009 SHALL have ports BRESP out 2, BVALID out 1, BREADY in 1: write response channel.
REQ-010 SHALL have port regs_o  out  NUM_REGS*DATA_WIDTH  flat register contents, register n at bits [32n+31:32n].

Function
REQ-011 SHALL decode the register index as addr[ADDR_WIDTH-1:2]; addr[1:0] ignored; ARPROT/AWPROT ignored.
REQ-012 SHALL treat an index >= NUM_REGS as out of range: response SLVERR (2'b10), no register change, RDATA 0.
REQ-013 SHALL respond OKAY (2'b00) for in-range accesses; no other response codes are used.
REQ-014 SHALL accept AW and W independently, in either order or in the same cycle, and latch each one.
REQ-015 SHALL drive AWREADY=1 only while no AW is latched and BVALID=0; WREADY is driven by the same rule for W.
REQ-016 SHALL commit the write on the edge where both AW and W are latched (or being handshaken), then assert BVALID on the next cycle.
REQ-017 SHALL apply byte enables: byte k of the register updates only when WSTRB[k]=1; WSTRB=0 writes nothing and still responds OKAY.
REQ-018 SHALL hold BVALID and BRESP stable until BREADY=1, then clear BVALID and reopen AWREADY/WREADY on the following cycle.
REQ-019 SHALL drive ARREADY=1 only while RVALID=0.
REQ-020 SHALL register RDATA/RRESP on the AR handshake edge and assert RVALID in the next cycle (1-cycle latency).
REQ-021 SHALL hold RVALID, RDATA and RRESP stable until RREADY=1.
REQ-022 SHALL service read and write channels concurrently; a read of a register written on the same edge returns the old value.
REQ-023 SHALL update regs_o on the same edge as the register write.

Reset
REQ-024 SHALL, while ARESET=1 at a rising ACLK edge, clear all registers and latched AW/W state, and drive ARREADY, AWREADY, WREADY, RVALID, BVALID low with RDATA, RRESP and BRESP at 0.
REQ-025 SHALL abandon any in-flight transaction on reset without issuing its response.
REQ-026 SHALL raise AWREADY, WREADY and ARREADY in the first cycle after ARESET deasserts.

Structure
REQ-027 SHALL take RESP_OKAY and RESP_SLVERR from a shared package (axil_pkg) together with the default widths.
REQ-028 SHALL be a single module with no sub-module; read and write paths are separate always blocks.

Verification
REQ-029 Write 0xDEADBEEF to 0x04 with WSTRB=0xF, then read 0x04 -> BRESP=OKAY, RDATA=0xDEADBEEF, regs_o[63:32]=0xDEADBEEF.
REQ-030 Write 0x11223344 to 0x08 with WSTRB=0x5 over a register holding 0 -> register reads 0x00220044.
REQ-031 W presented 3 cycles before AW at 0x0C -> single write committed, one BVALID pulse with OKAY.
REQ-032 Read 0x40 with NUM_REGS=16 -> RRESP=SLVERR, RDATA=0; write 0x40 -> BRESP=SLVERR, regs_o unchanged.
REQ-033 BREADY/RREADY held low for 5 cycles -> BVALID/RVALID and data held stable, AWREADY/ARREADY stay 0 until the handshake.
REQ-034 Assert ARESET mid-write after AW only -> no BVALID, all registers 0, a fresh write then completes normally.
